// File: rtl/sat_alu_pkg.sv
// Shared operation encoding and signed-extreme helpers for the saturating ALU pipeline.
package sat_alu_pkg;

    typedef enum logic [1:0] {
        OP_ADD  = 2'b00,
        OP_SUB  = 2'b01,
        OP_LTU  = 2'b10,
        OP_PASS = 2'b11
    } op_e;

    localparam int MAX_W = 64;

    // Bit patterns 0111...1 and 1000...0 for a w-bit two's-complement value.
    function automatic logic [MAX_W-1:0] signed_max(input int w);
        return (MAX_W'(1) << (w - 1)) - MAX_W'(1);
    endfunction

    function automatic logic [MAX_W-1:0] signed_min(input int w);
        return MAX_W'(1) << (w - 1);
    endfunction

endpackage

// File: rtl/sat_alu_core.sv
// Combinational ALU: signed add/sub with overflow detect, unsigned less-than, pass-through.
// Define SAT_ALU_SATURATE_EN to clamp overflowing results to the signed extreme instead of wrapping.
module sat_alu_core
    import sat_alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  op_e              op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] y,
    output logic             overflow
);

`ifdef SAT_ALU_SATURATE_EN
    localparam logic [WIDTH-1:0] SMAX = WIDTH'(signed_max(WIDTH));
    localparam logic [WIDTH-1:0] SMIN = WIDTH'(signed_min(WIDTH));
`endif

    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] diff;

    assign sum  = a + b;
    assign diff = a - b;

    // NOTE: every output gets a default first so no path through the case can infer a latch.
    always_comb begin
        y        = a;
        overflow = 1'b0;
        case (op)
            OP_ADD: begin
                y        = sum;
                overflow = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                y        = diff;
                overflow = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
            end
            OP_LTU:  y = {{(WIDTH-1){1'b0}}, (a < b)};
            default: y = a;
        endcase
`ifdef SAT_ALU_SATURATE_EN
        // On signed overflow the true result always carries the sign of a.
        if (overflow) begin
            y = a[WIDTH-1] ? SMIN : SMAX;
        end
`endif
    end

endmodule

// File: rtl/sat_alu_pipe.sv
// Two-stage valid/ready pipelined saturating ALU with a saturating overflow-event counter.
// Result clamping is enabled by defining SAT_ALU_SATURATE_EN (see sat_alu_core).
module sat_alu_pipe
    import sat_alu_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] y,
    output logic             overflow,
    input  logic             cnt_clr,
    output logic [CNT_W-1:0] ovf_count
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic             s1_valid_q, s1_valid_d;
    op_e              s1_op_q, s1_op_d;
    logic [WIDTH-1:0] s1_a_q, s1_a_d;
    logic [WIDTH-1:0] s1_b_q, s1_b_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] y_q, y_d;
    logic             overflow_q, overflow_d;
    logic [CNT_W-1:0] ovf_count_q, ovf_count_d;

    logic             s2_load;
    logic             in_fire;
    logic             out_fire;
    logic [WIDTH-1:0] core_y;
    logic             core_ovf;

    sat_alu_core #(.WIDTH(WIDTH)) u_core (
        .op       (s1_op_q),
        .a        (s1_a_q),
        .b        (s1_b_q),
        .y        (core_y),
        .overflow (core_ovf)
    );

    // in_ready looks only at state and out_ready, never at in_valid.
    assign s2_load  = s1_valid_q && (!out_valid_q || out_ready);
    assign in_ready = !s1_valid_q || s2_load;
    assign in_fire  = in_valid && in_ready;
    assign out_fire = out_valid_q && out_ready;

    always_comb begin
        s1_valid_d  = s1_valid_q;
        s1_op_d     = s1_op_q;
        s1_a_d      = s1_a_q;
        s1_b_d      = s1_b_q;
        out_valid_d = out_valid_q;
        y_d         = y_q;
        overflow_d  = overflow_q;
        ovf_count_d = ovf_count_q;

        if (in_fire) begin
            s1_valid_d = 1'b1;
            s1_op_d    = op_e'(op);
            s1_a_d     = a;
            s1_b_d     = b;
        end else if (s2_load) begin
            s1_valid_d = 1'b0;
        end

        if (s2_load) begin
            out_valid_d = 1'b1;
            y_d         = core_y;
            overflow_d  = core_ovf;
        end else if (out_fire) begin
            out_valid_d = 1'b0;
        end

        if (cnt_clr) begin
            ovf_count_d = '0;
        end else if (out_fire && overflow_q && (ovf_count_q != CNT_MAX)) begin
            ovf_count_d = ovf_count_q + 1'b1;
        end
    end

    // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
    // NOTE: datapath registers are reset too, so y reads 0 after reset rather than stale data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q  <= 1'b0;
            s1_op_q     <= OP_ADD;
            s1_a_q      <= '0;
            s1_b_q      <= '0;
            out_valid_q <= 1'b0;
            y_q         <= '0;
            overflow_q  <= 1'b0;
            ovf_count_q <= '0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_op_q     <= s1_op_d;
            s1_a_q      <= s1_a_d;
            s1_b_q      <= s1_b_d;
            out_valid_q <= out_valid_d;
            y_q         <= y_d;
            overflow_q  <= overflow_d;
            ovf_count_q <= ovf_count_d;
        end
    end

    assign out_valid = out_valid_q;
    assign y         = y_q;
    assign overflow  = overflow_q;
    assign ovf_count = ovf_count_q;

endmodule

// File: tb/tb_sat_alu_pipe.sv
// Self-checking bench for sat_alu_pipe (WIDTH=8) with a CNT_W=16 and a CNT_W=2 instance sharing stimulus.
module tb_sat_alu_pipe;

    localparam int W      = 8;
    localparam int SMAX_I = 127;
    localparam int SMIN_I = -128;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid, out_ready, cnt_clr;
    logic [1:0]   op;
    logic [W-1:0] a, b;
    logic         in_ready, out_valid, overflow;
    logic [W-1:0] y;
    logic [15:0]  ovf_count;
    logic         in_ready2, out_valid2, overflow2;
    logic [W-1:0] y2;
    logic [1:0]   ovf_count2;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    sat_alu_pipe #(.WIDTH(W), .CNT_W(16)) u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .op(op), .a(a), .b(b),
        .out_valid(out_valid), .out_ready(out_ready), .y(y), .overflow(overflow),
        .cnt_clr(cnt_clr), .ovf_count(ovf_count)
    );

    sat_alu_pipe #(.WIDTH(W), .CNT_W(2)) u_dut_c2 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready2), .op(op), .a(a), .b(b),
        .out_valid(out_valid2), .out_ready(out_ready), .y(y2), .overflow(overflow2),
        .cnt_clr(cnt_clr), .ovf_count(ovf_count2)
    );

    // Reference: exact integer arithmetic, then range check against the signed limits.
    function automatic void ref_alu(input logic [1:0] op_i, input logic [W-1:0] a_i, input logic [W-1:0] b_i,
                                    output logic [W-1:0] y_o, output logic ov_o);
        int sa, sb, t;
        sa   = $signed(a_i);
        sb   = $signed(b_i);
        ov_o = 1'b0;
        case (op_i)
            2'd0, 2'd1: begin
                t    = (op_i == 2'd0) ? sa + sb : sa - sb;
                ov_o = (t > SMAX_I) || (t < SMIN_I);
                y_o  = t[W-1:0];
`ifdef SAT_ALU_SATURATE_EN
                if (t > SMAX_I) y_o = 8'h7F;
                if (t < SMIN_I) y_o = 8'h80;
`endif
            end
            2'd2:    y_o = (a_i < b_i) ? 8'd1 : 8'd0;
            default: y_o = a_i;
        endcase
    endfunction

    task automatic do_reset;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; cnt_clr = 1'b0;
        op = 2'd0; a = '0; b = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    // Issue one beat into an idle pipe, then scramble inputs and wait a bounded time for the result.
    task automatic run_beat(input logic [1:0] op_i, input logic [W-1:0] a_i, input logic [W-1:0] b_i,
                            output logic [W-1:0] y_o, output logic ov_o, output int lat);
        @(posedge clk); #1;
        in_valid = 1'b1; op = op_i; a = a_i; b = b_i; out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; op = 2'($urandom); a = 8'($urandom); b = 8'($urandom);
        lat = -1; y_o = '0; ov_o = 1'b0;
        for (int n = 1; n <= 6 && lat < 0; n++) begin
            @(negedge clk);
            if (out_valid) begin
                lat = n; y_o = y; ov_o = overflow;
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset;
        rst = 1'b1; in_valid = 1'b1; out_ready = 1'b0; cnt_clr = 1'b0;
        op = 2'd3; a = 8'h5A; b = 8'h11;
        repeat (3) @(posedge clk);
        #1;
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_out_valid: got %b exp 0", out_valid); end
        n_checks++; if (y !== 8'h00) begin n_fail++; $display("FAIL rst_y: got %h exp 00", y); end
        n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL rst_overflow: got %b exp 0", overflow); end
        n_checks++; if (ovf_count !== 16'd0) begin n_fail++; $display("FAIL rst_ovf_count: got %0d exp 0", ovf_count); end
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_in_ready: got %b exp 1", in_ready); end
        in_valid = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_release_out_valid: got %b exp 0", out_valid); end
    endtask

    task automatic test_arith;
        logic [1:0]   t_op [10] = '{2'd0, 2'd1, 2'd1, 2'd0, 2'd0, 2'd2, 2'd2, 2'd3, 2'd2, 2'd1};
        logic [W-1:0] t_a  [10] = '{8'd100, 8'h9C, 8'd5, 8'h80, 8'h7F, 8'd3, 8'd200, 8'hA5, 8'd5, 8'h80};
        logic [W-1:0] t_b  [10] = '{8'd50, 8'd50, 8'd7, 8'h80, 8'h81, 8'd200, 8'd3, 8'h5A, 8'd5, 8'h01};
`ifdef SAT_ALU_SATURATE_EN
        logic [W-1:0] t_y  [10] = '{8'h7F, 8'h80, 8'hFE, 8'h80, 8'h00, 8'h01, 8'h00, 8'hA5, 8'h00, 8'h80};
`else
        logic [W-1:0] t_y  [10] = '{8'h96, 8'h6A, 8'hFE, 8'h00, 8'h00, 8'h01, 8'h00, 8'hA5, 8'h00, 8'h7F};
`endif
        logic         t_ov [10] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        int           t_cnt[10] = '{1, 2, 2, 3, 3, 3, 3, 3, 3, 4};
        logic [W-1:0] yv;
        logic         ov;
        int           lat;
        do_reset;
        for (int i = 0; i < 10; i++) begin
            run_beat(t_op[i], t_a[i], t_b[i], yv, ov, lat);
            n_checks++; if (lat != 2) begin n_fail++; $display("FAIL arith%0d_latency: got %0d exp 2", i, lat); end
            n_checks++; if (yv !== t_y[i]) begin n_fail++; $display("FAIL arith%0d_y: got %h exp %h", i, yv, t_y[i]); end
            n_checks++; if (ov !== t_ov[i]) begin n_fail++; $display("FAIL arith%0d_overflow: got %b exp %b", i, ov, t_ov[i]); end
            n_checks++; if (ovf_count !== 16'(t_cnt[i])) begin n_fail++; $display("FAIL arith%0d_count: got %0d exp %0d", i, ovf_count, t_cnt[i]); end
            n_checks++; if (ovf_count2 !== 2'((t_cnt[i] > 3) ? 3 : t_cnt[i])) begin n_fail++; $display("FAIL arith%0d_count2: got %0d", i, ovf_count2); end
        end
    endtask

    task automatic test_back_to_back;
        int sent = 0;
        int recv = 0;
        int stall = 0;
        bit seen_first = 1'b0;
        bit saw_block = 1'b0;
        do_reset;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk); #1;
            out_ready = (stall == 0);
            if (stall > 0) stall--;
            in_valid = (sent < 4);
            op = 2'd3; a = 8'(8'h10 + sent); b = 8'($urandom);
            @(negedge clk);
            if (in_valid && !in_ready) saw_block = 1'b1;
            if (out_valid && out_ready) begin
                n_checks++;
                if (recv >= 4 || y !== 8'(8'h10 + recv)) begin
                    n_fail++; $display("FAIL b2b_beat%0d: got %h exp %h", recv, y, 8'(8'h10 + recv));
                end
                recv++;
                if (!seen_first) begin seen_first = 1'b1; stall = 3; end
            end
            if (in_valid && in_ready) sent++;
        end
        @(posedge clk); #1 in_valid = 1'b0;
        n_checks++; if (sent != 4) begin n_fail++; $display("FAIL b2b_sent: got %0d exp 4", sent); end
        n_checks++; if (recv != 4) begin n_fail++; $display("FAIL b2b_recv: got %0d exp 4", recv); end
        n_checks++; if (!saw_block) begin n_fail++; $display("FAIL b2b_in_ready_drop: got never-low exp low"); end
    endtask

    task automatic test_cnt_sat;
        do_reset;
        out_ready = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            in_valid = 1'b1; op = 2'd0; a = 8'h7F; b = 8'h01;
        end
        @(posedge clk); #1 in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        n_checks++; if (ovf_count !== 16'd5) begin n_fail++; $display("FAIL sat_count16: got %0d exp 5", ovf_count); end
        n_checks++; if (ovf_count2 !== 2'd3) begin n_fail++; $display("FAIL sat_count2: got %0d exp 3", ovf_count2); end
        in_valid = 1'b1; op = 2'd1; a = 8'h80; b = 8'h01;
        @(posedge clk); #1 in_valid = 1'b0;
        @(posedge clk); #1 cnt_clr = 1'b1;
        @(negedge clk);
        n_checks++; if (!(out_valid && overflow)) begin n_fail++; $display("FAIL clr_precond: got valid=%b ovf=%b exp 1 1", out_valid, overflow); end
        @(posedge clk); #1 cnt_clr = 1'b0;
        n_checks++; if (ovf_count !== 16'd0) begin n_fail++; $display("FAIL clr_wins16: got %0d exp 0", ovf_count); end
        n_checks++; if (ovf_count2 !== 2'd0) begin n_fail++; $display("FAIL clr_wins2: got %0d exp 0", ovf_count2); end
    endtask

    task automatic test_reset_midflight;
        logic [W-1:0] yv;
        logic         ov;
        int           lat;
        do_reset;
        run_beat(2'd0, 8'h7F, 8'h01, yv, ov, lat);
        @(posedge clk); #1;
        out_ready = 1'b0; in_valid = 1'b1; op = 2'd0; a = 8'h7F; b = 8'h7F;
        @(posedge clk); #1;
        op = 2'd3; a = 8'h33;
        @(posedge clk); #1;
        in_valid = 1'b0;
        n_checks++; if (!(out_valid && !in_ready)) begin n_fail++; $display("FAIL mid_precond: got valid=%b in_ready=%b exp 1 0", out_valid, in_ready); end
        rst = 1'b1;
        #1;
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL mid_rst_out_valid: got %b exp 0", out_valid); end
        n_checks++; if (ovf_count !== 16'd0) begin n_fail++; $display("FAIL mid_rst_count: got %0d exp 0", ovf_count); end
        @(posedge clk); #1;
        rst = 1'b0; out_ready = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL mid_stale_beat: got out_valid=%b y=%h exp 0", out_valid, y); end
        end
        n_checks++; if (ovf_count !== 16'd0) begin n_fail++; $display("FAIL mid_after_count: got %0d exp 0", ovf_count); end
    endtask

    typedef struct {
        logic [W-1:0] y;
        logic         ov;
        bit           in_s2;
    } beat_t;

    task automatic test_random;
        beat_t        q[$];
        beat_t        h;
        logic [W-1:0] edge_vals [4] = '{8'h7F, 8'h80, 8'h00, 8'hFF};
        logic [W-1:0] ey;
        logic         eov;
        int           m_cnt = 0;
        int           m_cnt2 = 0;
        bit           m_out_valid, m_in_ready, in_f, out_f;
        do_reset;
        for (int c = 0; c < 400; c++) begin
            @(posedge clk); #1;
            in_valid  = ($urandom_range(0, 9) < 7);
            out_ready = ($urandom_range(0, 9) < 7);
            cnt_clr   = ($urandom_range(0, 31) == 0);
            op        = 2'($urandom);
            a = ($urandom_range(0, 3) == 0) ? edge_vals[$urandom_range(0, 3)] : 8'($urandom);
            b = ($urandom_range(0, 3) == 0) ? edge_vals[$urandom_range(0, 3)] : 8'($urandom);
            @(negedge clk);
            m_out_valid = (q.size() > 0) && q[0].in_s2;
            m_in_ready  = !(q.size() == 2 && !out_ready);
            n_checks++; if (out_valid !== m_out_valid || out_valid2 !== m_out_valid) begin
                n_fail++; $display("FAIL rnd%0d_out_valid: got %b/%b exp %b", c, out_valid, out_valid2, m_out_valid);
            end
            n_checks++; if (in_ready !== m_in_ready || in_ready2 !== m_in_ready) begin
                n_fail++; $display("FAIL rnd%0d_in_ready: got %b/%b exp %b", c, in_ready, in_ready2, m_in_ready);
            end
            if (m_out_valid) begin
                n_checks++; if (y !== q[0].y || overflow !== q[0].ov || y2 !== q[0].y || overflow2 !== q[0].ov) begin
                    n_fail++; $display("FAIL rnd%0d_result: got %h/%b exp %h/%b", c, y, overflow, q[0].y, q[0].ov);
                end
            end
            n_checks++; if (ovf_count !== 16'(m_cnt) || ovf_count2 !== 2'(m_cnt2)) begin
                n_fail++; $display("FAIL rnd%0d_count: got %0d/%0d exp %0d/%0d", c, ovf_count, ovf_count2, m_cnt, m_cnt2);
            end
            in_f  = in_valid && m_in_ready;
            out_f = m_out_valid && out_ready;
            if (cnt_clr) begin
                m_cnt = 0; m_cnt2 = 0;
            end else if (out_f && q[0].ov) begin
                if (m_cnt < 65535) m_cnt++;
                if (m_cnt2 < 3) m_cnt2++;
            end
            if (out_f) void'(q.pop_front());
            if (q.size() > 0 && !q[0].in_s2) begin
                h = q.pop_front(); h.in_s2 = 1'b1; q.push_front(h);
            end
            if (in_f) begin
                ref_alu(op, a, b, ey, eov);
                h.y = ey; h.ov = eov; h.in_s2 = 1'b0;
                q.push_back(h);
            end
        end
        @(posedge clk); #1;
        in_valid = 1'b0; cnt_clr = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset;
        test_arith;
        test_back_to_back;
        test_cnt_sat;
        test_reset_midflight;
        test_random;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sat_alu_pipe.md
# sat_alu_pipe

Parametrised, two-stage pipelined saturating ALU: signed add, signed subtract, unsigned less-than compare and pass-through on WIDTH-bit operands, with per-result overflow flag and a saturating overflow-event counter. Successor to the fixed 8-bit combinational ALU datapath, which forces the result and overflow outputs on signed overflow. It sits between the operand issue logic and the result writeback, with valid/ready handshakes on both sides.

## Interface
- WIDTH, 8, operand/result width in bits (≥2)
- CNT_W, 16, overflow-event counter width (≥1)
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  operand beat valid
- in_ready  out  1  stage 1 can accept a beat
- op  in  2  operation: 00 ADD, 01 SUB, 10 LTU, 11 PASS
- a  in  WIDTH  operand A (two's complement for ADD/SUB)
- b  in  WIDTH  operand B
- out_valid  out  1  result beat valid
- out_ready  in  1  consumer accepts result
- y  out  WIDTH  result
- overflow  out  1  signed overflow for this result
- cnt_clr  in  1  synchronous clear of ovf_count
- ovf_count  out  CNT_W  number of accepted results with overflow=1, saturating

## Operation
- Stage 1 registers op, a, b on in_valid && in_ready.
- Stage 2 computes result from stage-1 registers and registers y, overflow.
- ADD: s = a + b (WIDTH+1-bit signed); overflow = sign(a)==sign(b) && sign(s[WIDTH-1:0])!=sign(a).
- SUB: s = a − b; overflow = sign(a)!=sign(b) && sign(s[WIDTH-1:0])!=sign(a).
- On overflow with positive true result, y = 0111…1; negative true result, y = 1000…0 (see Configuration).
- LTU: y = {WIDTH-1 zeros, (a < b unsigned)}; overflow = 0.
- PASS: y = a; overflow = 0.
- ovf_count increments on out_valid && out_ready && overflow; holds at 2^CNT_W−1.
- cnt_clr clears ovf_count; clear wins over a simultaneous increment.

## Timing
- Latency 2 cycles from input handshake to out_valid; throughput one beat per cycle when out_ready stays high.
- Stage advance: s2_load = s1_valid && (!out_valid || out_ready); in_ready = !s1_valid || s2_load. No combinational path from in_valid to in_ready; in_ready depends on out_ready combinationally (registered skid not required).
- out_valid, y, overflow stable while out_valid && !out_ready.
- Stage-1 valid clears on s2_load unless a new beat is accepted in the same cycle.
- Reset values: in_ready=1 (derived), out_valid=0, y=0, overflow=0, ovf_count=0, stage-1 valid=0.
- Reset mid-operation discards both in-flight beats; no output beat emitted for them.
- op values latched at stage 1; changes on op while in_valid=0 have no effect.

## Configuration
- SAT_ALU_SATURATE_EN defined: on overflow, y clamps to the signed extreme as described; overflow flag asserted.
- Undefined: y is the wrapped WIDTH-bit sum/difference; overflow flag and ovf_count behave identically.

## Structure
- Package sat_alu_pkg: op enum (OP_ADD, OP_SUB, OP_LTU, OP_PASS), localparam helpers for signed max/min of a given width.
- Sub-module sat_alu_core: purely combinational compute (op, a, b → y, overflow), parametrised by WIDTH; sat_alu_pipe owns registers, handshakes and counter.

## Test plan
- WIDTH=8, SATURATE_EN: ADD 100+50 → y=0x7F, overflow=1, ovf_count=1 two cycles later; without macro → y=0x96, overflow=1.
- SUB 0x9C(−100) − 50 → y=0x80, overflow=1; SUB 5−7 → y=0xFE, overflow=0.
- LTU a=3, b=200 → y=0x01; a=200, b=3 → y=0x00; PASS a=0xA5 → y=0xA5.
- Back-to-back 4 beats with out_ready low for 3 cycles after first result → in_ready drops after 2 held beats, no beat lost or duplicated, order preserved.
- CNT_W=2: 5 overflowing results → ovf_count sticks at 3; cnt_clr asserted in same cycle as an overflowing handshake → ovf_count=0.
- rst asserted with two beats in flight → out_valid=0 immediately, no stale result after release, ovf_count=0.
